// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared read/write port of the word memory.
// Registers the memory strobes and routes read data / write completion back to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_resp,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_resp,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              mem_act_read,
    output logic              mem_act_write,
    output logic [ADDR_W-1:0] mem_select,
    output logic [DATA_W-1:0] mem_input,
    input  logic [DATA_W-1:0] mem_output,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]        state;
    logic              lastGrant;
    logic              curWrite;
    logic [2:0]        waitCnt;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              pick;
    logic              pickWrite;
    logic [ADDR_W-1:0] pickAddr;
    logic [DATA_W-1:0] pickWdata;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || lastGrant);
        grant1     = req1_valid && (!req0_valid || !lastGrant);
        req0_ready = !reset && (state == IDLE) && grant0;
        req1_ready = !reset && (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        pick       = grant1;
        pickWrite  = pick ? req1_write : req0_write;
        pickAddr   = pick ? req1_addr  : req0_addr;
        pickWdata  = pick ? req1_wdata : req0_wdata;
    end

    always_comb begin
        busy       = (state != IDLE);
        req0_rdata = (req0_resp && !curWrite) ? mem_output : '0;
        req1_rdata = (req1_resp && !curWrite) ? mem_output : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lastGrant     <= 1'b1;
            curWrite      <= 1'b0;
            waitCnt       <= '0;
            owner         <= 1'b0;
            mem_act_read  <= 1'b0;
            mem_act_write <= 1'b0;
            mem_select    <= '0;
            mem_input     <= '0;
            req0_resp     <= 1'b0;
            req1_resp     <= 1'b0;
        end else begin
            mem_act_read  <= 1'b0;
            mem_act_write <= 1'b0;
            mem_select    <= '0;
            mem_input     <= '0;
            req0_resp     <= 1'b0;
            req1_resp     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= ACCESS;
                        owner         <= pick;
                        lastGrant     <= pick;
                        curWrite      <= pickWrite;
                        mem_act_write <= pickWrite;
                        mem_act_read  <= !pickWrite;
                        mem_select    <= pickAddr;
                        mem_input     <= pickWrite ? pickWdata : '0;
                    end
                end
                ACCESS: begin
                    if (curWrite || READ_LATENCY == 1) begin
                        state     <= RESP;
                        req0_resp <= !owner;
                        req1_resp <= owner;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= 3'(READ_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (waitCnt == 3'd1) begin
                        state     <= RESP;
                        waitCnt   <= '0;
                        req0_resp <= !owner;
                        req1_resp <= owner;
                    end else begin
                        waitCnt <= waitCnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each with a behavioural memory behind port 1.
module tb_mem_port_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clock;
    logic rst;

    logic          r0v, r0w, r0rdy, r0resp, r1v, r1w, r1rdy, r1resp;
    logic [AW-1:0] r0a, r1a, mSel;
    logic [DW-1:0] r0d, r1d, r0rd, r1rd, mIn, mOut;
    logic          mRd, mWr, busyA, ownerA;

    logic          b0v, b0w, b0rdy, b0resp, b1v, b1w, b1rdy, b1resp;
    logic [AW-1:0] b0a, b1a, bSel;
    logic [DW-1:0] b0d, b1d, b0rd, b1rd, bIn, bOut;
    logic          bRd, bWr, busyB, ownerB;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT_A)) dutA (
        .clock(clock), .reset(rst),
        .req0_valid(r0v), .req0_write(r0w), .req0_addr(r0a), .req0_wdata(r0d),
        .req0_ready(r0rdy), .req0_resp(r0resp), .req0_rdata(r0rd),
        .req1_valid(r1v), .req1_write(r1w), .req1_addr(r1a), .req1_wdata(r1d),
        .req1_ready(r1rdy), .req1_resp(r1resp), .req1_rdata(r1rd),
        .mem_act_read(mRd), .mem_act_write(mWr), .mem_select(mSel), .mem_input(mIn),
        .mem_output(mOut), .busy(busyA), .owner(ownerA)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT_B)) dutB (
        .clock(clock), .reset(rst),
        .req0_valid(b0v), .req0_write(b0w), .req0_addr(b0a), .req0_wdata(b0d),
        .req0_ready(b0rdy), .req0_resp(b0resp), .req0_rdata(b0rd),
        .req1_valid(b1v), .req1_write(b1w), .req1_addr(b1a), .req1_wdata(b1d),
        .req1_ready(b1rdy), .req1_resp(b1resp), .req1_rdata(b1rd),
        .mem_act_read(bRd), .mem_act_write(bWr), .mem_select(bSel), .mem_input(bIn),
        .mem_output(bOut), .busy(busyB), .owner(ownerB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memories: read data appears LAT cycles after the strobe cycle, poison otherwise.
    logic [DW-1:0] memA [0:1023];
    logic [DW-1:0] pipeA;
    always @(posedge clock) begin
        if (mWr) memA[mSel] <= mIn;
        pipeA <= mRd ? memA[mSel] : 32'hBAD0BAD0;
    end
    assign mOut = pipeA;

    logic [DW-1:0] memB [0:1023];
    logic [DW-1:0] pipeB [0:2];
    always @(posedge clock) begin
        if (bWr) memB[bSel] <= bIn;
        pipeB[0] <= bRd ? memB[bSel] : 32'hBAD0BAD0;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign bOut = pipeB[2];

    int nChecks = 0;
    int nErr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nErr++;
        $display("FAIL %s: timed out waiting for ready, required ready within bound", name);
    endtask

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cycle;
    } sbEnt;

    sbEnt          sbQ[$];
    sbEnt          got;
    logic [DW-1:0] modelRam [0:1023];

    task automatic pushExp(input logic port, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int c);
        sbEnt e;
        if (wr) modelRam[addr] = wdata;
        e.port  = port;
        e.data  = wr ? 32'h0 : modelRam[addr];
        e.cycle = c + (wr ? 2 : 1 + LAT_A);
        sbQ.push_back(e);
    endtask

    always @(negedge clock) begin
        if (r0resp || r1resp) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nErr++;
                $display("FAIL unexpected_resp: resp0=%0b resp1=%0b, required no resp", r0resp, r1resp);
            end else begin
                got = sbQ.pop_front();
                check("resp_port", 32'({r1resp, r0resp}), got.port ? 32'd2 : 32'd1);
                check("resp_rdata", got.port ? r1rd : r0rd, got.data);
                check("resp_cycle", 32'(cyc), 32'(got.cycle));
            end
        end
    end

    typedef struct {
        logic          v0, v1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          g;
    } vecRec;

    function automatic vecRec mk(input logic v0, input logic v1, input logic w0, input logic w1,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic g);
        vecRec r;
        r.v0 = v0; r.v1 = v1; r.w0 = w0; r.w1 = w1;
        r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1; r.g = g;
        return r;
    endfunction

    task automatic applyVec(input vecRec v);
        int            c;
        int            gap;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(posedge clock); #1;
        r0v = v.v0; r1v = v.v1; r0w = v.w0; r1w = v.w1;
        r0a = v.a0; r1a = v.a1; r0d = v.d0; r1d = v.d1;
        @(negedge clock);
        check("grant_ready", 32'({r1rdy, r0rdy}), v.g ? 32'd2 : 32'd1);
        w = v.g ? v.w1 : v.w0;
        a = v.g ? v.a1 : v.a0;
        d = v.g ? v.d1 : v.d0;
        c = cyc;
        pushExp(v.g, w, a, d, c);
        @(posedge clock); #1;
        r0v = 1'b0; r1v = 1'b0;
        @(negedge clock);
        check("access_strobes", 32'({mWr, mRd}), w ? 32'd2 : 32'd1);
        check("access_select", 32'(mSel), 32'(a));
        check("access_input", mIn, w ? d : 32'h0);
        check("access_owner", 32'(ownerA), 32'(v.g));
        gap = w ? 3 : 2 + LAT_A;
        while (cyc < c + gap) @(negedge clock);
        check("idle_busy", 32'(busyA), 32'd0);
        check("sb_drained", 32'(sbQ.size()), 32'd0);
    endtask

    task automatic drain();
        int k = 0;
        while ((busyA || sbQ.size() != 0) && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("drain_busy", 32'(busyA), 32'd0);
        check("drain_sb", 32'(sbQ.size()), 32'd0);
    endtask

    vecRec tbl [0:10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int k;
        int c;
        int prevC;

        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h005, 10'h000, 32'hDEADBEEF, 32'h0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h005, 10'h000, 32'h0, 32'h0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 10'h000, 10'h002, 32'h0, 32'h22222222, 1'b1);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 10'h000, 32'h11111111, 32'h0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h001, 10'h002, 32'h0, 32'h0, 1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 10'h003, 10'h004, 32'h33333333, 32'h44444444, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h005, 10'h001, 32'h0, 32'h0, 1'b1);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'h003, 10'h3FF, 32'h0, 32'hFFFFFFFF, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 10'h3FF, 32'h0, 32'h0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 10'h002, 32'hA5A5A5A5, 32'h0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 32'h0, 32'h0, 1'b0);

        rst = 1'b1;
        r0v = 1'b1; r0w = 1'b0; r0a = '0; r0d = '0;
        r1v = 1'b0; r1w = 1'b0; r1a = '0; r1d = '0;
        b0v = 1'b0; b0w = 1'b0; b0a = '0; b0d = '0;
        b1v = 1'b0; b1w = 1'b0; b1a = '0; b1d = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_ready0", 32'(r0rdy), 32'd0);
        check("reset_busy", 32'(busyA), 32'd0);
        check("reset_owner", 32'(ownerA), 32'd0);
        check("reset_strobes", 32'({mWr, mRd}), 32'd0);
        check("reset_select", 32'(mSel), 32'd0);
        check("reset_input", mIn, 32'd0);
        check("reset_resp", 32'({r1resp, r0resp}), 32'd0);
        check("reset_rdata", r0rd | r1rd, 32'd0);
        check("reset_busy_b", 32'(busyB), 32'd0);
        rst = 1'b0;
        r0v = 1'b0;

        for (int i = 0; i < 11; i++) applyVec(tbl[i]);

        // requester 1 streams writes alone; a new accept every third cycle
        @(posedge clock); #1;
        r1v = 1'b1; r1w = 1'b1; r1a = 10'h010; r1d = 32'h10000000;
        prevC = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            @(negedge clock);
            while (!r1rdy && k < 10) begin
                @(negedge clock);
                k++;
            end
            if (!r1rdy) begin
                timeoutFail("stream_ready");
                r1v = 1'b0;
                break;
            end
            c = cyc;
            check("stream_ready0", 32'(r0rdy), 32'd0);
            if (i > 0) check("stream_gap", 32'(c - prevC), 32'd3);
            prevC = c;
            pushExp(1'b1, 1'b1, r1a, r1d, c);
            @(posedge clock); #1;
            if (i == 3) r1v = 1'b0;
            else begin
                r1a = r1a + 10'd1;
                r1d = r1d + 32'd1;
            end
        end
        drain();

        // both requesters continuously valid: grants alternate 0,1,0,1 with no bubble
        @(posedge clock); #1;
        r0v = 1'b1; r0w = 1'b0; r0a = 10'h001;
        r1v = 1'b1; r1w = 1'b0; r1a = 10'h002;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            @(negedge clock);
            while (!(r0rdy || r1rdy) && k < 10) begin
                @(negedge clock);
                k++;
            end
            if (!(r0rdy || r1rdy)) begin
                timeoutFail("contend_ready");
                break;
            end
            c = cyc;
            check("contend_grant", 32'({r1rdy, r0rdy}), (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) check("contend_gap", 32'(c - prevC), 32'(2 + LAT_A));
            prevC = c;
            pushExp(r1rdy, 1'b0, r1rdy ? r1a : r0a, 32'h0, c);
            @(posedge clock); #1;
        end
        r0v = 1'b0; r1v = 1'b0;
        drain();

        // asynchronous reset between edges while the write strobe is up
        @(posedge clock); #1;
        r0v = 1'b1; r0w = 1'b1; r0a = 10'h020; r0d = 32'h12345678;
        @(posedge clock); #1;
        r0v = 1'b0;
        @(negedge clock);
        check("async_pre_strobe", 32'({mWr, mRd}), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("async_strobes", 32'({mWr, mRd}), 32'd0);
        check("async_select", 32'(mSel), 32'd0);
        check("async_busy", 32'(busyA), 32'd0);
        check("async_owner", 32'(ownerA), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        repeat (3) @(negedge clock);
        check("async_no_resp_sb", 32'(sbQ.size()), 32'd0);

        // latency-3 instance: reset during WAIT drops the read
        @(posedge clock); #1;
        b0v = 1'b1; b0w = 1'b0; b0a = 10'h007;
        @(negedge clock);
        check("b_ready0", 32'(b0rdy), 32'd1);
        @(posedge clock); #1;
        b0v = 1'b0;
        @(negedge clock);
        check("b_access_read", 32'({bWr, bRd}), 32'd1);
        @(negedge clock);
        check("b_wait_busy", 32'(busyB), 32'd1);
        check("b_wait_strobes", 32'({bWr, bRd}), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("b_reset_busy", 32'(busyB), 32'd0);
        check("b_reset_strobes", 32'({bWr, bRd}), 32'd0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clock);
            if (j == 1) rst = 1'b0;
            check("b_no_resp", 32'({b1resp, b0resp}), 32'd0);
        end

        // after reset a tie goes to requester 0
        @(posedge clock); #1;
        b0v = 1'b1; b0w = 1'b1; b0a = 10'h007; b0d = 32'h77777777;
        b1v = 1'b1; b1w = 1'b1; b1a = 10'h008; b1d = 32'h88888888;
        @(negedge clock);
        check("b_tie_grant", 32'({b1rdy, b0rdy}), 32'd1);
        c = cyc;
        @(posedge clock); #1;
        b0v = 1'b0; b1v = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clock);
            check("b_write_resp0", 32'(b0resp), 32'(cyc == c + 2));
            check("b_write_resp1", 32'(b1resp), 32'd0);
        end

        @(posedge clock); #1;
        b0v = 1'b1; b0w = 1'b0; b0a = 10'h007;
        @(negedge clock);
        check("b_read_ready", 32'(b0rdy), 32'd1);
        c = cyc;
        @(posedge clock); #1;
        b0v = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clock);
            check("b_read_resp0", 32'(b0resp), 32'(cyc == c + 1 + LAT_B));
            if (cyc == c + 1 + LAT_B) check("b_read_rdata", b0rd, 32'h77777777);
        end

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the read/write port of the word memory (10-bit select, 32-bit data) between two requesters, e.g. the CPU data path (requester 0) and a loader/DMA engine (requester 1). Arbitrates round-robin, registers and sequences the memory strobes, and routes the read data or write acknowledgement back to the owning requester. Sits between the requesters and the memory's port 1. Port 2, the read-only instruction port, is not touched.

Parameters:
ADDR_W, 10, memory select width
DATA_W, 32, memory word width
READ_LATENCY, 1, cycles from the strobe cycle to valid data on mem_output; legal range 1..4

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a transaction
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
req0_ready  out  1  transaction accepted this cycle
req0_resp  out  1  one-cycle completion pulse (read data valid / write done)
req0_rdata  out  DATA_W  read data, meaningful only when req0_resp=1
req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_resp, req1_rdata  (same as requester 0, for requester 1)
mem_act_read  out  1  memory read strobe
mem_act_write  out  1  memory write strobe
mem_select  out  ADDR_W  memory address
mem_input  out  DATA_W  memory write data
mem_output  in  DATA_W  memory read data
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  requester owning the current transaction (0 in IDLE)

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all registered outputs 0 (mem_act_read, mem_act_write, mem_select, mem_input, req*_resp, req*_rdata, busy, owner); last_grant=1, so requester 0 wins the first tie; wait counter=0.
- Reset mid-transaction: the in-flight transaction is dropped. No resp is issued and no memory strobe remains asserted.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: grant is combinational.
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqK_ready = (state==IDLE) && grantK. Accept happens on valid&&ready in cycle N.
  - On accept: latch write, addr, wdata and owner; update last_grant; go to ACCESS.
- ACCESS (cycle N+1): exactly one of mem_act_read/mem_act_write = 1, with mem_select = latched addr and mem_input = latched wdata (0 for reads).
  - Write → RESP.
  - Read with READ_LATENCY=1 → RESP.
  - Read otherwise → WAIT, with counter loaded to READ_LATENCY-1.
- WAIT: strobes 0; decrement counter; → RESP when counter reaches 1.
- RESP: owner's resp=1 for exactly one cycle.
  - Read: rdata = mem_output sampled in this cycle.
  - Write: rdata = 0.
  - Next state is IDLE. The non-owner's resp stays 0.
- Strobes, mem_select and mem_input are 0 in every state except ACCESS.
- Timing: write completes at N+2. Read completes at N+1+READ_LATENCY.
  - Minimum issue interval is 3 cycles for writes and 2+READ_LATENCY for reads.
  - No idle bubble beyond the IDLE accept cycle.
- Requesters hold valid/addr/wdata/write stable until ready. Deasserting valid before ready is allowed; no transaction is issued.
- A valid arriving while busy waits; ready stays 0 until IDLE.
- Round-robin guarantees that neither requester waits more than one transaction of the other.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req0_valid=1 → all outputs 0, req0_ready=0. Assert reset asynchronously between edges → outputs clear without a clock edge.
- Single write: req0 write addr 0x005, data 0xDEADBEEF, accepted cycle N → N+1: mem_act_write=1, mem_select=0x005, mem_input=0xDEADBEEF. N+2: req0_resp=1. N+3: busy=0.
- Read back with READ_LATENCY=1: req0 read 0x005 → N+1: mem_act_read=1. N+2: req0_resp=1, req0_rdata=0xDEADBEEF. req1_resp stays 0 throughout.
- Contention: req0 and req1 continuously valid with reads of 0x001/0x002 → grants alternate 0,1,0,1; owner and resp routing match each grant.
- Single requester streaming: only req1 valid for 4 writes → accepted every 3 cycles, all grants go to requester 1, and req0 signals stay 0.
- Reset in WAIT with READ_LATENCY=3: reset asserted one cycle after ACCESS → no resp, strobes 0. After release, a simultaneous req0/req1 tie is granted to requester 0.
